// File: rtl/dmem_copy_engine_pkg.sv
// Shared definitions for the DMem copy engine: FSM encoding and the
// address/data width defaults shared with DMem.
package dmem_copy_engine_pkg;

    localparam int DMEM_AW = 4;
    localparam int DMEM_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } copy_state_t;

    // The CPU loses the DMem port in every state except IDLE.
    function automatic logic engine_owns_bus(input copy_state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/dmem_copy_engine_if.sv
// Simple single-port memory bus, used for both the CPU side and the DMem side.
interface dmem_copy_engine_if
    import dmem_copy_engine_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
);

    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (
        output en,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  en,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/dmem_copy_engine.sv
// DMem access stage: passes CPU requests through when idle, otherwise runs a
// forward block copy inside DMem (one read + one write per byte) and stalls the CPU.
module dmem_copy_engine
    import dmem_copy_engine_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW,
    parameter int LW = AW + 1
)
(
    input  logic                clk,
    input  logic                rst_n,
    dmem_copy_engine_if.slave   cpu,
    dmem_copy_engine_if.master  mem,
    input  logic                Start,
    input  logic [AW-1:0]       SrcAddr,
    input  logic [AW-1:0]       DstAddr,
    input  logic [LW-1:0]       Len,
    output logic                Busy,
    output logic                Done,
    output logic                Stall
);

    localparam logic [LW-1:0] MAX_LEN = LW'(2 ** AW);

    copy_state_t   state;
    copy_state_t   state_nxt;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [LW-1:0] count;
    logic [DW-1:0] byte_buf;
    logic [LW-1:0] len_clamped;

    // Lengths beyond the memory size would only re-copy bytes, so cap them.
    assign len_clamped = (Len > MAX_LEN) ? MAX_LEN : Len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt = (len_clamped == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD:   state_nxt = ST_WR;
            ST_WR:   state_nxt = (count == LW'(1)) ? ST_DONE : ST_RD;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            byte_buf <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        src_ptr <= SrcAddr;
                        dst_ptr <= DstAddr;
                        count   <= len_clamped;
                    end
                end
                ST_RD: begin
                    byte_buf <= mem.rdata;
                end
                ST_WR: begin
                    // Pointers wrap modulo the memory size by plain overflow.
                    src_ptr <= src_ptr + AW'(1);
                    dst_ptr <= dst_ptr + AW'(1);
                    count   <= count - LW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem.en    = 1'b0;
        mem.we    = 1'b0;
        mem.addr  = '0;
        mem.wdata = '0;
        cpu.rdata = '0;
        Busy      = (state == ST_RD) || (state == ST_WR);
        Done      = (state == ST_DONE);
        Stall     = engine_owns_bus(state);
        case (state)
            ST_IDLE: begin
                if (cpu.en) begin
                    mem.en    = 1'b1;
                    mem.we    = cpu.we;
                    mem.addr  = cpu.addr;
                    mem.wdata = cpu.wdata;
                end
                cpu.rdata = mem.rdata;
            end
            ST_RD: begin
                mem.en   = 1'b1;
                mem.addr = src_ptr;
            end
            ST_WR: begin
                mem.en    = 1'b1;
                mem.we    = 1'b1;
                mem.addr  = dst_ptr;
                mem.wdata = byte_buf;
            end
            default: ;
        endcase
    end

    // Done is a single-cycle pulse and is always followed by IDLE.
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) Done |=> !Done);
    a_stall_def:  assert property (@(posedge clk) disable iff (!rst_n) Stall == (Busy | Done));

endmodule
